therm_to_bin_pipe: RTL and testbench
====================================

THERM_TO_BIN_PIPE -- requirements
Module: therm_to_bin_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving thermometer code width (legal range 2..64).
REQ-002 SHALL have derived localparam BIN_W = $clog2(DATA_WIDTH+1), giving binary output width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port code_in  input  DATA_WIDTH  thermometer code from flash comparator bank.
REQ-006 SHALL have port in_valid  input  1  code_in valid.
REQ-007 SHALL have port in_ready  output  1  block accepts code_in this cycle.
REQ-008 SHALL have port bin_out  output  BIN_W  decoded level.
REQ-009 SHALL have port out_err  output  1  the beat's code was not a legal thermometer code.
REQ-010 SHALL have port out_valid  output  1  bin_out/out_err valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output.
REQ-012 SHALL have port err_cnt  output  8  saturating count of accepted error beats.

Function
REQ-013 A legal code SHALL be 2^k-1 for k in 0..DATA_WIDTH: ones contiguous from bit 0, all-zeros and all-ones both legal.
REQ-014 Two register stages SHALL be used: S1 captures code_in, S2 holds the decoded bin_out/out_err.
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal !s1_valid || s1_move, where s1_move = s1_valid && (!s2_valid || out_ready).
REQ-017 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, at a throughput of 1 beat/cycle.
REQ-018 out_valid SHALL equal s2_valid; bin_out/out_err SHALL hold stable while out_valid && !out_ready.
REQ-019 For a legal code, bin_out SHALL equal k and out_err SHALL be 0.
REQ-020 For an illegal code, bin_out SHALL equal the popcount of the (corrected, per REQ-027) code and out_err SHALL be 1.
REQ-021 err_cnt SHALL increment by 1 on each output transfer with out_err=1, saturate at 255, and never wrap.
REQ-022 Simultaneous input and output transfers SHALL both take effect with no bubble and no data loss.
REQ-023 No beat SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-024 resetn low SHALL asynchronously clear s1_valid, s2_valid and err_cnt to 0, and clear bin_out and out_err to 0.
REQ-025 Reset asserted mid-stream SHALL discard in-flight beats; the first beat after deassertion SHALL see empty stages (in_ready=1).
REQ-026 in_ready SHALL be 1 while in reset.

Configuration
REQ-027 With macro THERM_BUBBLE_FIX_EN defined, S2 SHALL first replace each bit i with majority(c[i-1], c[i], c[i+1]) of the original code, with c[-1]=1 and c[DATA_WIDTH]=0, then apply REQ-013..REQ-020.
REQ-028 Without THERM_BUBBLE_FIX_EN, the raw code SHALL be checked and decoded unmodified, and latency SHALL be unchanged.

Verification (DATA_WIDTH=8, BIN_W=4)
REQ-029 Streaming case: send codes 8'h00, 8'h01, 8'h7F, 8'hFF on consecutive cycles with out_ready=1 -> bin_out 0, 1, 7, 8 appear 2 cycles later, out_err=0, err_cnt=0.
REQ-030 Illegal-code case: send 8'b0001_0111 without the macro -> bin_out=4, out_err=1, err_cnt=1; with THERM_BUBBLE_FIX_EN -> bin_out=4, out_err=0, err_cnt=0.
REQ-031 Backpressure case: send 4 beats with out_ready=0 -> in_ready falls after 2 accepted beats and outputs stay stable; raising out_ready -> all 4 beats emerge in order with none lost.
REQ-032 Saturation case: send 300 beats of 8'h0A with out_ready=1 -> err_cnt reaches 255 and stays at 255.
REQ-033 Reset case: assert resetn low while 2 beats are in flight -> out_valid=0 and err_cnt=0 immediately, and in_ready=1; after release, a new beat 8'h03 -> bin_out=2.
REQ-034 Random case: random in_valid/out_ready at 50% with random codes -> output stream matches a reference model beat-for-beat.

Source files
------------

// File: rtl/therm_to_bin_pipe.sv
// Two-stage thermometer-to-binary decoder with valid/ready handshakes and a saturating error counter.
// Optional macro THERM_BUBBLE_FIX_EN enables 3-input majority bubble correction ahead of the decode.
module therm_to_bin_pipe #(
  parameter int DATA_WIDTH = 8,
  localparam int BIN_W = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] code_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            err_cnt
);

  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_code_reg;
  logic                  s2_valid_reg;
  logic [BIN_W-1:0]      bin_reg;
  logic                  err_reg;
  logic [7:0]            err_cnt_reg;

  logic                  s1_move;
  logic [DATA_WIDTH-1:0] fixed_code;
  logic [DATA_WIDTH:0]   code_inc;
  logic [BIN_W-1:0]      pop_next;
  logic                  err_next;

  assign s1_move  = s1_valid_reg && (!s2_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s1_move;

`ifdef THERM_BUBBLE_FIX_EN
  // Pad with a 1 below bit 0 and a 0 above the MSB so the ends vote like a clean code.
  logic [DATA_WIDTH+1:0] ext_code;
  assign ext_code = {1'b0, s1_code_reg, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_maj
      assign fixed_code[gi] = (ext_code[gi] & ext_code[gi+1]) |
                              (ext_code[gi] & ext_code[gi+2]) |
                              (ext_code[gi+1] & ext_code[gi+2]);
    end
  endgenerate
`else
  assign fixed_code = s1_code_reg;
`endif

  // A legal code is 2^k-1, so adding one clears every set bit; any overlap means a stray one.
  assign code_inc = {1'b0, fixed_code} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign err_next = (fixed_code & code_inc[DATA_WIDTH-1:0]) != '0;

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pop_next = pop_next + BIN_W'(fixed_code[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_code_reg <= code_in;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_reg <= 1'b0;
      bin_reg      <= '0;
      err_reg      <= 1'b0;
    end else if (s1_move) begin
      s2_valid_reg <= 1'b1;
      bin_reg      <= pop_next;
      err_reg      <= err_next;
    end else if (out_ready) begin
      s2_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_reg <= 8'd0;
    end else if (s2_valid_reg && out_ready && err_reg && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign bin_out   = bin_reg;
  assign out_err   = err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_therm_to_bin_pipe.sv
// Directed and random scoreboard bench for therm_to_bin_pipe at DATA_WIDTH=8.
// Follows THERM_BUBBLE_FIX_EN in its reference model so it can check either build.
module tb_therm_to_bin_pipe;

  localparam int W  = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [W-1:0]  code_in;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] bin_out;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    err_cnt;

  therm_to_bin_pipe #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .code_in   (code_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bin;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int            cyc       = 0;
  int            model_cnt = 0;
  logic          acc       = 1'b0;
  logic          chk_lat   = 1'b0;
  logic          stalled   = 1'b0;
  logic [BW-1:0] held_bin;
  logic          held_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Majority-vote correction and a first-zero scan, written independently of the RTL.
  function automatic exp_t ref_decode(input logic [W-1:0] raw);
    exp_t       r;
    logic [W-1:0] c;
    logic [W-1:0] mask;
    int         k;
    int         pop;
    int         tmp;
`ifdef THERM_BUBBLE_FIX_EN
    for (int i = 0; i < W; i++) begin
      logic lo, hi;
      lo   = (i == 0) ? 1'b1 : raw[i-1];
      hi   = (i == W-1) ? 1'b0 : raw[i+1];
      c[i] = (lo & raw[i]) | (lo & hi) | (raw[i] & hi);
    end
`else
    c = raw;
`endif
    k = 0;
    while (k < W && c[k]) k++;
    tmp  = (1 << k) - 1;
    mask = tmp[W-1:0];
    pop  = 0;
    for (int i = 0; i < W; i++) pop += int'(c[i]);
    r.bin = pop[BW-1:0];
    r.err = (c != mask);
    r.cyc = 0;
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (stalled) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bin", 32'(bin_out), 32'(held_bin));
      check("hold_err", 32'(out_err), 32'(held_err));
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e     = ref_decode(code_in);
      e.cyc = cyc;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("bin_out", 32'(bin_out), 32'(e.bin));
        check("out_err", 32'(out_err), 32'(e.err));
        check("err_cnt_live", 32'(err_cnt), 32'(model_cnt));
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        if (e.err && model_cnt < 255) model_cnt++;
      end
    end
    stalled  = out_valid && !out_ready;
    held_bin = bin_out;
    held_err = out_err;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("err_cnt_model", 32'(err_cnt), 32'(model_cnt));
  endtask

  task automatic send_wait(input logic [W-1:0] code);
    int n;
    code_in  = code;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc && n < 20);
    check("send_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] stream_codes [4];
    int           rk;
    int           rv;

    stream_codes[0] = 8'h00;
    stream_codes[1] = 8'h01;
    stream_codes[2] = 8'h7F;
    stream_codes[3] = 8'hFF;

    resetn    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    code_in   = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Streaming, back-to-back with latency check
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code_in = stream_codes[i];
      tick();
      check("stream_acc", 32'(acc), 32'd1);
    end
    drain();
    chk_lat = 1'b0;
    check("stream_err_cnt", 32'(err_cnt), 32'd0);

    // Single illegal code
    send_wait(8'b0001_0111);
    drain();
`ifdef THERM_BUBBLE_FIX_EN
    check("illegal_err_cnt", 32'(err_cnt), 32'd0);
`else
    check("illegal_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Backpressure: only two beats fit while the output is stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 8'h01;
    tick();
    check("bp_acc0", 32'(acc), 32'd1);
    code_in = 8'h03;
    tick();
    check("bp_acc1", 32'(acc), 32'd1);
    code_in = 8'h07;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_blocked", 32'(acc), 32'd0);
    end
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send_wait(8'h07);
    send_wait(8'h0F);
    drain();

    // Saturation of the error counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    code_in   = 8'h0A;
    repeat (300) tick();
    drain();
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    repeat (3) tick();
    check("sat_hold", 32'(err_cnt), 32'd255);

    // Reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    code_in   = 8'h01;
    tick();
    code_in = 8'h03;
    tick();
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    model_cnt = 0;
    stalled   = 1'b0;
    #2 resetn = 1'b1;
    out_ready = 1'b1;
    send_wait(8'h03);
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        rk = $urandom_range(0, W);
        rv = (1 << rk) - 1;
      end else begin
        rv = int'($urandom);
      end
      code_in = rv[W-1:0];
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
